// File: rtl/psw_flag_register.sv
// psw_flag_register: NZVC JK flag register with direct load, save/restore LIFO and branch condition decode
module psw_flag_register #(
    parameter int STACK_DEPTH = 4,
    parameter int DEPTH_W     = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               J_N,
    input  logic               K_N,
    input  logic               J_Z,
    input  logic               K_Z,
    input  logic               J_V,
    input  logic               K_V,
    input  logic               J_C,
    input  logic               K_C,
    input  logic               psw_ld,
    input  logic [3:0]         psw_din,
    input  logic               push,
    input  logic               pop,
    input  logic [3:0]         cond,
    output logic [3:0]         psw_q,
    output logic               branch_taken,
    output logic [DEPTH_W-1:0] stk_depth,
    output logic               stk_full,
    output logic               stk_empty,
    output logic               stk_err
);
    logic [3:0]         stk_q [2**DEPTH_W];
    logic [DEPTH_W-1:0] depth_q, depth_d, top_idx;
    logic [3:0]         psw_d, jk, j, k;
    logic               err_q, err_d, push_ok, pop_ok, n, z, v, c, lt;
    always_comb begin
        stk_full  = depth_q == DEPTH_W'(STACK_DEPTH);
        stk_empty = depth_q == '0;
        push_ok   = push & ~pop & ~stk_full;
        pop_ok    = pop & ~push & ~stk_empty;
        err_d     = (push & pop) | (push & ~pop & stk_full) | (pop & ~push & stk_empty);
        top_idx   = stk_empty ? '0 : depth_q - 1'b1;
        j         = {J_N, J_Z, J_V, J_C};
        k         = {K_N, K_Z, K_V, K_C};
        jk        = (j & ~psw_q) | (~k & psw_q);
        psw_d     = pop_ok ? stk_q[top_idx] : psw_ld ? psw_din : jk;
        depth_d   = push_ok ? depth_q + 1'b1 : pop_ok ? depth_q - 1'b1 : depth_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psw_q   <= '0;
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            psw_q   <= psw_d;
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push_ok) stk_q[depth_q] <= psw_q;
    end
    always_comb begin
        {n, z, v, c} = psw_q;
        lt           = n ^ v;
        branch_taken = 1'b0;
        case (cond)
            4'd0:    branch_taken = 1'b1;
            4'd1:    branch_taken = z;
            4'd2:    branch_taken = ~z;
            4'd3:    branch_taken = lt;
            4'd4:    branch_taken = lt | z;
            4'd5:    branch_taken = ~lt;
            4'd6:    branch_taken = ~(lt | z);
            4'd7:    branch_taken = c;
            4'd8:    branch_taken = ~c;
            4'd9:    branch_taken = n;
            4'd10:   branch_taken = ~n;
            4'd11:   branch_taken = v;
            4'd12:   branch_taken = ~v;
            default: branch_taken = 1'b0;
        endcase
    end
    assign stk_depth = depth_q;
    assign stk_err   = err_q;
endmodule
